// File: rtl/frog_move_ctrl.sv
// frog_move_ctrl: turns button presses, collisions and goal arrivals into move/reset
// pulses, lives and score. Optional macro FROG_HOLD_REPEAT_EN makes held buttons repeat.
`default_nettype none

module frog_move_ctrl #(
  parameter int unsigned COOLDOWN_CYC = 8,
  parameter int unsigned LIVES        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_l,
  input  logic       btn_d,
  input  logic       btn_u,
  input  logic       btn_r,
  input  logic [3:0] row_in,
  input  logic       hit,
  input  logic       start,
  output logic       l,
  output logic       d,
  output logic       u,
  output logic       r,
  output logic       frog_rst,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {ARMED, COOL, DEAD, OVER} state_t;

  localparam logic [7:0] CD_LOAD   = 8'(COOLDOWN_CYC);
  localparam logic [1:0] LIVES_LD  = 2'(LIVES);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] btn_prev;
  logic [3:0] btns;
  logic [3:0] press;

  // Bit order {u, d, l, r} puts the highest-priority button in the MSB.
  assign btns = {btn_u, btn_d, btn_l, btn_r};

  always_comb begin
`ifdef FROG_HOLD_REPEAT_EN
    press = btns;
`else
    press = btns & ~btn_prev;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ARMED;
      cnt       <= 8'd0;
      btn_prev  <= 4'd0;
      l         <= 1'b0;
      d         <= 1'b0;
      u         <= 1'b0;
      r         <= 1'b0;
      frog_rst  <= 1'b0;
      lives     <= LIVES_LD;
      score     <= 8'd0;
      game_over <= 1'b0;
    end else begin
      btn_prev <= btns;
      l        <= 1'b0;
      d        <= 1'b0;
      u        <= 1'b0;
      r        <= 1'b0;
      frog_rst <= 1'b0;
      case (state)
        ARMED, COOL: begin
          // Collision beats goal arrival, which beats any move in the same cycle.
          if (hit) begin
            frog_rst <= 1'b1;
            if (lives == 2'd1) begin
              lives     <= 2'd0;
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              lives <= lives - 2'd1;
              state <= DEAD;
              cnt   <= CD_LOAD;
            end
          end else if (row_in == 4'hF) begin
            frog_rst <= 1'b1;
            if (score != 8'hFF) score <= score + 8'd1;
            state <= COOL;
            cnt   <= CD_LOAD;
          end else if (state == ARMED) begin
            if (|press) begin
              state <= COOL;
              cnt   <= CD_LOAD;
              if (press[3])      u <= 1'b1;
              else if (press[2]) d <= 1'b1;
              else if (press[1]) l <= 1'b1;
              else               r <= 1'b1;
            end
          end else if (cnt == 8'd0) begin
            state <= ARMED;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DEAD: begin
          if (cnt == 8'd0) state <= ARMED;
          else             cnt   <= cnt - 8'd1;
        end
        OVER: begin
          if (start) begin
            lives     <= LIVES_LD;
            score     <= 8'd0;
            frog_rst  <= 1'b1;
            state     <= ARMED;
            game_over <= 1'b0;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/frog_move_ctrl.md
FROG_MOVE_CTRL -- requirements
Module: frog_move_ctrl

Interface
REQ-001 Parameter: COOLDOWN_CYC, 8, cycles after an accepted move before the next move is accepted (legal range 1..255).
REQ-002 Parameter: LIVES, 3, lives loaded at reset and on start (legal range 1..3).
REQ-003 Port: clock  input  1  single clock; all state updates on the posedge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: btn_l, btn_d, btn_u, btn_r  input  1 each  synchronized button levels.
REQ-006 Port: row_in  input  4  current frog row from the position block (0 = start row, 15 = goal row).
REQ-007 Port: hit  input  1  collision level from the hazard logic.
REQ-008 Port: start  input  1  restart request; honoured only in OVER.
REQ-009 Port: l, d, u, r  output  1 each  registered one-cycle move pulses to the position block.
REQ-010 Port: frog_rst  output  1  registered one-cycle pulse that returns the frog to its start position.
REQ-011 Port: lives  output  2  remaining lives.
REQ-012 Port: score  output  8  completed crossings, saturating at 255.
REQ-013 Port: game_over  output  1  high while in OVER.

Function
REQ-014 States: ARMED, COOL, DEAD, OVER.
REQ-015 Press detect: a button press is its rising edge (level high this cycle, low the previous cycle); the previous-cycle level is registered for each button.
REQ-016 ARMED: a press is accepted; when several presses occur in one cycle, only the highest priority is accepted, in the order u > d > l > r.
REQ-017 Move timing: a press accepted at edge N drives exactly one pulse on the matching output during cycle N+1, then ARMED -> COOL.
REQ-018 Pulse exclusivity: at most one of l, d, u, r, frog_rst is high in any cycle.
REQ-019 COOL: an 8-bit counter loads COOLDOWN_CYC on entry and decrements each cycle; at 0 the FSM returns to ARMED.
REQ-020 Presses during COOL or DEAD are dropped, not queued.
REQ-021 Win: row_in == 15 sampled in ARMED or COOL (with hit low) pulses frog_rst next cycle, increments score (saturating; 255 + 1 = 255), then goes to COOL with the counter reloaded.
REQ-022 Hit: hit high in ARMED or COOL pulses frog_rst next cycle and decrements lives.
REQ-023 Hit exit: if lives was 1 before the decrement, lives becomes 0 and the FSM goes to OVER; otherwise it goes to DEAD.
REQ-024 DEAD: the counter loads COOLDOWN_CYC, hit is ignored, and the FSM goes to ARMED when the counter reaches 0.
REQ-025 Same-cycle priority: hit > win > move; the lower-priority events in that cycle are discarded.
REQ-026 OVER: game_over = 1 and no move pulses are issued.
REQ-027 OVER exit: start reloads lives = LIVES, clears score, pulses frog_rst next cycle, and goes to ARMED; start in any other state is ignored.
REQ-028 Position limits: clamping at rows and columns 0/15 is done by the position block; this block emits pulses regardless of position.

Reset
REQ-029 Reset values: FSM = ARMED, counter = 0, lives = LIVES, score = 0, l/d/u/r/frog_rst = 0, game_over = 0, button history = 0.
REQ-030 Mid-operation reset: reset asserted in any state, including mid-COOL or mid-DEAD, forces the REQ-029 values asynchronously; the first press after release is accepted normally.

Configuration
REQ-031 Macro FROG_HOLD_REPEAT_EN defined: in ARMED, a button held high counts as a press (level rather than edge), so holding repeats a move every COOLDOWN_CYC+2 cycles; priority per REQ-016 still applies.
REQ-032 Macro FROG_HOLD_REPEAT_EN undefined: only rising edges count as presses, and holding produces exactly one move.

Verification
REQ-033 Reset, then btn_u rises for 1 cycle -> u high for exactly 1 cycle, at cycle N+1; a second btn_u edge 3 cycles later is dropped (COOLDOWN_CYC = 8).
REQ-034 btn_u and btn_r rise in the same cycle in ARMED -> only u pulses; r never pulses.
REQ-035 hit and btn_l in the same cycle with lives = 3 -> frog_rst pulses, lives = 2, no l pulse, no move accepted for 8 cycles.
REQ-036 Three hits separated by >10 cycles -> lives goes 2, 1, 0; game_over = 1; btn_u is ignored; start -> lives = 3, score = 0, frog_rst pulses, ARMED.
REQ-037 row_in = 15 with score = 255 -> frog_rst pulses and score stays 255; row_in = 15 together with hit -> lives decrements and score is unchanged.
REQ-038 btn_d held 40 cycles -> with FROG_HOLD_REPEAT_EN, 4 d pulses spaced 10 cycles apart; without it, exactly 1 d pulse.
